// File: rtl/ebox_tlm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ebox_tlm_pkg
//  Purpose  : Shared constants and types for the Ebox telemetry shifter path.
//  Revision : 1.0  initial release
// ============================================================================
package ebox_tlm_pkg;

    localparam int WORD_BITS = 10;

    typedef logic [WORD_BITS-1:0] word_t;

    localparam word_t SYNC_WORD = 10'h3C5;
    localparam word_t FILL_WORD = 10'h2AA;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    typedef enum logic {
        SRC_SCI = 1'b0,
        SRC_HK  = 1'b1
    } src_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shifter_frame_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shifter_frame_ctrl_if
//  Purpose  : Source handshakes, shifter drive and status of the frame sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface shifter_frame_ctrl_if;
    import ebox_tlm_pkg::*;

    logic        enable;
    logic        sci_valid;
    word_t       sci_data;
    logic        sci_ready;
    logic        hk_valid;
    word_t       hk_data;
    logic        hk_ready;
    logic        sh_enable;
    logic        sh_loadn;
    word_t       sh_dbus;
    logic        frame_start;
    logic [7:0]  word_idx;
    logic [15:0] underrun_cnt;

    // master is the frame sequencer, slave is the surrounding Ebox logic
    modport master (
        input  enable, sci_valid, sci_data, hk_valid, hk_data,
        output sci_ready, hk_ready, sh_enable, sh_loadn, sh_dbus,
               frame_start, word_idx, underrun_cnt
    );

    modport slave (
        output enable, sci_valid, sci_data, hk_valid, hk_data,
        input  sci_ready, hk_ready, sh_enable, sh_loadn, sh_dbus,
               frame_start, word_idx, underrun_cnt
    );

endinterface
`default_nettype wire

// File: rtl/gclk_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gclk_edge_det
//  Purpose  : Two-flop synchronizer with rising-edge pulse for the gated gclk.
//  Revision : 1.0  initial release
// ============================================================================
module gclk_edge_det (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic async_in,
    output logic      rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule
`default_nettype wire

// File: rtl/shifter_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : shifter_frame_ctrl
//  Purpose  : Frame sequencer and sci/hk round-robin arbiter for the 10-bit shifter.
//  Revision : 1.0  initial release
// ============================================================================
module shifter_frame_ctrl
    import ebox_tlm_pkg::*;
#(
    parameter int FRAME_WORDS = 16
) (
    input  wire logic             clk50,
    input  wire logic             rst_n,
    input  wire logic             gclk,
    shifter_frame_ctrl_if.master  bus
);

    localparam int              CNT_BITS = $clog2(WORD_BITS + 1);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WORD_BITS - 1);
    localparam logic [7:0]      LAST_IDX = 8'(FRAME_WORDS - 1);

    logic                gclk_rise;
    logic [1:0]          state;
    logic [CNT_BITS-1:0] bit_cnt;
    src_e                rr_ptr;

    logic                sh_enable_q;
    logic                sh_loadn_q;
    word_t               sh_dbus_q;
    logic                sci_ready_q;
    logic                hk_ready_q;
    logic                frame_start_q;
    logic [7:0]          word_idx_q;
    logic [15:0]         underrun_q;

    logic                load_now;
    logic [7:0]          idx_sel;
    logic                is_sync;
    logic                grant_sci;
    logic                grant_hk;
    logic                is_fill;
    word_t               word_sel;

    gclk_edge_det u_gclk_edge (
        .clk      (clk50),
        .rst_n    (rst_n),
        .async_in (gclk),
        .rise     (gclk_rise)
    );

    // A load is scheduled one cycle ahead so the outputs land registered in the LOAD cycle.
    always_comb begin
        load_now = 1'b0;
        idx_sel  = 8'd0;
        if (bus.enable) begin
            case (state)
                ST_IDLE: begin
                    load_now = 1'b1;
                    idx_sel  = 8'd0;
                end
                ST_SHIFT: begin
                    if (gclk_rise && (bit_cnt == LAST_BIT)) begin
                        load_now = 1'b1;
                        idx_sel  = (word_idx_q == LAST_IDX) ? 8'd0 : word_idx_q + 8'd1;
                    end
                end
                default: begin
                    load_now = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        is_sync   = (idx_sel == 8'd0);
        grant_sci = !is_sync && bus.sci_valid && (!bus.hk_valid || (rr_ptr == SRC_SCI));
        grant_hk  = !is_sync && bus.hk_valid && (!bus.sci_valid || (rr_ptr == SRC_HK));
        is_fill   = !is_sync && !grant_sci && !grant_hk;
        if (is_sync) begin
            word_sel = SYNC_WORD;
        end else if (grant_sci) begin
            word_sel = bus.sci_data;
        end else if (grant_hk) begin
            word_sel = bus.hk_data;
        end else begin
            word_sel = FILL_WORD;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rr_ptr        <= SRC_SCI;
            sh_enable_q   <= 1'b0;
            sh_loadn_q    <= 1'b1;
            sh_dbus_q     <= '0;
            sci_ready_q   <= 1'b0;
            hk_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            word_idx_q    <= 8'd0;
            underrun_q    <= 16'd0;
        end else if (!bus.enable) begin
            // Dropping enable abandons the frame; a gclk edge in this cycle is ignored.
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            sh_enable_q   <= 1'b0;
            sh_loadn_q    <= 1'b1;
            sci_ready_q   <= 1'b0;
            hk_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            word_idx_q    <= 8'd0;
        end else begin
            sh_loadn_q    <= 1'b1;
            sci_ready_q   <= 1'b0;
            hk_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    state       <= ST_LOAD;
                    sh_enable_q <= 1'b1;
                end
                ST_LOAD: begin
                    state   <= ST_SHIFT;
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (load_now) begin
                        state   <= ST_LOAD;
                        bit_cnt <= '0;
                    end else if (gclk_rise) begin
                        bit_cnt <= bit_cnt + CNT_BITS'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase

            if (load_now) begin
                sh_loadn_q    <= 1'b0;
                sh_dbus_q     <= word_sel;
                word_idx_q    <= idx_sel;
                frame_start_q <= is_sync;
                sci_ready_q   <= grant_sci;
                hk_ready_q    <= grant_hk;
                if (grant_sci) begin
                    rr_ptr <= SRC_HK;
                end else if (grant_hk) begin
                    rr_ptr <= SRC_SCI;
                end
                if (is_fill) begin
                    underrun_q <= sat_inc16(underrun_q);
                end
            end
        end
    end

    assign bus.sh_enable    = sh_enable_q;
    assign bus.sh_loadn     = sh_loadn_q;
    assign bus.sh_dbus      = sh_dbus_q;
    assign bus.sci_ready    = sci_ready_q;
    assign bus.hk_ready     = hk_ready_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.word_idx     = word_idx_q;
    assign bus.underrun_cnt = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_shifter_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_shifter_frame_ctrl
//  Purpose  : Directed self-checking bench for shifter_frame_ctrl (FRAME_WORDS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shifter_frame_ctrl;

    logic clk50;
    logic rst_n;
    logic gclk;
    logic gclk_run;

    shifter_frame_ctrl_if bus();

    shifter_frame_ctrl #(.FRAME_WORDS(4)) dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .gclk  (gclk),
        .bus   (bus)
    );

    typedef struct packed {
        logic [9:0]  dbus;
        logic        fs;
        logic        sr;
        logic        hr;
        logic [7:0]  idx;
        logic [15:0] urun;
        logic [31:0] edges;
    } load_t;

    load_t       loads[$];
    logic [31:0] raw_edges;
    int          cnt_sci;
    int          cnt_hk;
    int          bad_ready;
    int          n_cmp;
    int          n_err;
    int          base;
    int          snap;
    int          nload;

    logic [9:0] exp1 [5] = '{10'h3C5, 10'h2AA, 10'h2AA, 10'h2AA, 10'h3C5};
    logic [9:0] exp2 [8] = '{10'h3C5, 10'h111, 10'h222, 10'h111, 10'h3C5, 10'h222, 10'h111, 10'h222};
    logic [9:0] exp3 [8] = '{10'h3C5, 10'h222, 10'h222, 10'h222, 10'h3C5, 10'h111, 10'h222, 10'h111};

    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end

    // 10 MHz gated clock, phase-offset from clk50; held low while stopped
    initial begin
        gclk = 1'b0;
        #3;
        forever #50 gclk = gclk_run ? ~gclk : 1'b0;
    end

    initial raw_edges = 0;
    always @(posedge gclk) raw_edges <= raw_edges + 1;

    always @(negedge clk50) begin
        if (rst_n && !bus.sh_loadn)
            loads.push_back(load_t'{bus.sh_dbus, bus.frame_start, bus.sci_ready,
                                    bus.hk_ready, bus.word_idx, bus.underrun_cnt, raw_edges});
    end

    initial begin
        cnt_sci = 0;
        cnt_hk = 0;
        bad_ready = 0;
    end
    always @(negedge clk50) begin
        if (rst_n) begin
            if (bus.sci_ready) cnt_sci <= cnt_sci + 1;
            if (bus.hk_ready)  cnt_hk  <= cnt_hk + 1;
            if ((bus.sci_ready || bus.hk_ready) && (bus.sh_loadn || (bus.sci_ready && bus.hk_ready)))
                bad_ready <= bad_ready + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_loads(input int n, input string tag);
        int cyc = 0;
        while ((loads.size() < n) && (cyc < 2000)) begin
            @(negedge clk50);
            cyc++;
        end
        check_val(tag, (loads.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        gclk_run = 1'b1;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.sci_valid = 1'b0;
        bus.hk_valid = 1'b0;
        bus.sci_data = 10'h111;
        bus.hk_data = 10'h222;
        repeat (3) @(negedge clk50);

        check_val("rst_sh_enable", {31'd0, bus.sh_enable}, 32'd0);
        check_val("rst_sh_loadn",  {31'd0, bus.sh_loadn}, 32'd1);
        check_val("rst_sh_dbus",   {22'd0, bus.sh_dbus}, 32'd0);
        check_val("rst_readies",   {30'd0, bus.sci_ready, bus.hk_ready}, 32'd0);
        check_val("rst_fs_idx",    {23'd0, bus.frame_start, bus.word_idx}, 32'd0);
        check_val("rst_underrun",  {16'd0, bus.underrun_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk50);

        // ---- idle sources: sync then fills
        base = loads.size();
        bus.enable = 1'b1;
        @(negedge clk50);
        check_val("t1_first_enable", {31'd0, bus.sh_enable}, 32'd1);
        check_val("t1_first_loadn",  {31'd0, bus.sh_loadn}, 32'd0);
        wait_loads(base + 5, "t1_wait");
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("t1_dbus%0d", i), {22'd0, loads[base+i].dbus}, {22'd0, exp1[i]});
            check_val($sformatf("t1_fs%0d", i), {31'd0, loads[base+i].fs}, (i == 0 || i == 4) ? 32'd1 : 32'd0);
            check_val($sformatf("t1_idx%0d", i), {24'd0, loads[base+i].idx}, (i == 4) ? 32'd0 : i);
        end
        for (int i = 2; i < 5; i++)
            check_val($sformatf("t1_period%0d", i), loads[base+i].edges - loads[base+i-1].edges, 32'd10);
        check_val("t1_underrun", {16'd0, loads[base+4].urun}, 32'd3);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk50);

        // ---- both sources valid continuously
        bus.sci_valid = 1'b1;
        bus.hk_valid = 1'b1;
        base = loads.size();
        snap = cnt_sci + cnt_hk;
        bus.enable = 1'b1;
        wait_loads(base + 8, "t2_wait");
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t2_dbus%0d", i), {22'd0, loads[base+i].dbus}, {22'd0, exp2[i]});
            check_val($sformatf("t2_sr%0d", i), {31'd0, loads[base+i].sr}, (exp2[i] == 10'h111) ? 32'd1 : 32'd0);
            check_val($sformatf("t2_hr%0d", i), {31'd0, loads[base+i].hr}, (exp2[i] == 10'h222) ? 32'd1 : 32'd0);
        end
        check_val("t2_period", loads[base+3].edges - loads[base+2].edges, 32'd10);
        check_val("t2_underrun", {16'd0, loads[base+7].urun}, 32'd3);
        @(negedge clk50);
        check_val("t2_ready_count", cnt_sci + cnt_hk - snap, 32'd6);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk50);

        // ---- hk only for three slots, then both
        bus.sci_valid = 1'b0;
        base = loads.size();
        bus.enable = 1'b1;
        wait_loads(base + 4, "t3_wait_a");
        bus.sci_valid = 1'b1;
        wait_loads(base + 8, "t3_wait_b");
        for (int i = 0; i < 8; i++)
            check_val($sformatf("t3_dbus%0d", i), {22'd0, loads[base+i].dbus}, {22'd0, exp3[i]});
        bus.enable = 1'b0;
        repeat (3) @(negedge clk50);

        // ---- enable dropped mid word 2, then re-enabled
        base = loads.size();
        bus.enable = 1'b1;
        wait_loads(base + 3, "t4_wait");
        check_val("t4_idx2", {24'd0, loads[base+2].idx}, 32'd2);
        repeat (4) @(posedge gclk);
        repeat (3) @(negedge clk50);
        snap = cnt_sci + cnt_hk;
        nload = loads.size();
        bus.enable = 1'b0;
        @(negedge clk50);
        check_val("t4_drop_enable", {31'd0, bus.sh_enable}, 32'd0);
        check_val("t4_drop_loadn",  {31'd0, bus.sh_loadn}, 32'd1);
        check_val("t4_drop_idx",    {24'd0, bus.word_idx}, 32'd0);
        repeat (60) @(negedge clk50);
        check_val("t4_no_ready", cnt_sci + cnt_hk - snap, 32'd0);
        check_val("t4_no_load", loads.size() - nload, 32'd0);
        bus.enable = 1'b1;
        @(negedge clk50);
        check_val("t4_re_loadn", {31'd0, bus.sh_loadn}, 32'd0);
        check_val("t4_re_dbus",  {22'd0, bus.sh_dbus}, 32'h3C5);
        check_val("t4_re_fs",    {31'd0, bus.frame_start}, 32'd1);
        check_val("t4_re_ready", {30'd0, bus.sci_ready, bus.hk_ready}, 32'd0);

        // ---- asynchronous reset in the middle of a shifting word
        wait_loads(nload + 2, "t5_wait");
        check_val("t5_word1_hk", {22'd0, loads[nload+1].dbus}, 32'h222);
        repeat (3) @(posedge gclk);
        #7;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_enable", {31'd0, bus.sh_enable}, 32'd0);
        check_val("t5_rst_loadn",  {31'd0, bus.sh_loadn}, 32'd1);
        check_val("t5_rst_dbus",   {22'd0, bus.sh_dbus}, 32'd0);
        check_val("t5_rst_idx",    {24'd0, bus.word_idx}, 32'd0);
        check_val("t5_rst_underrun", {16'd0, bus.underrun_cnt}, 32'd0);
        @(negedge clk50);
        bus.sci_valid = 1'b0;
        bus.hk_valid = 1'b0;
        repeat (2) @(negedge clk50);
        base = loads.size();
        rst_n = 1'b1;

        // ---- gclk stalled mid word 1
        wait_loads(base + 2, "t6_wait_a");
        check_val("t6_first_sync", {22'd0, loads[base].dbus}, 32'h3C5);
        check_val("t6_w1_fill",    {22'd0, loads[base+1].dbus}, 32'h2AA);
        check_val("t6_w1_urun",    {16'd0, loads[base+1].urun}, 32'd1);
        repeat (3) @(posedge gclk);
        gclk_run = 1'b0;
        nload = loads.size();
        repeat (200) @(negedge clk50);
        check_val("t6_no_load_stall", loads.size() - nload, 32'd0);
        gclk_run = 1'b1;
        wait_loads(base + 3, "t6_wait_b");
        check_val("t6_period", loads[base+2].edges - loads[base+1].edges, 32'd10);
        check_val("t6_w2_idx",  {24'd0, loads[base+2].idx}, 32'd2);
        check_val("t6_w2_urun", {16'd0, loads[base+2].urun}, 32'd2);

        check_val("ready_outside_load", bad_ready, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shifter_frame_ctrl.md
# shifter_frame_ctrl

Frame sequencer and source arbiter for the 10-bit parallel-to-serial shifter in the Ebox telemetry path. It watches the same 10 MHz gated clock as the shifter and counts shifted bits. At each word boundary it pulses the shifter load and presents the next word. Each frame is built from a sync word followed by data words arbitrated round-robin between a science source and a housekeeping source, with fill words when both are idle.

## Interface
- WORD_BITS, 10, shifter word width; must equal the shifter's n+1
- FRAME_WORDS, 16, words per frame including the sync word; range 2..255
- SYNC_WORD, 10'h3C5, word 0 of every frame
- FILL_WORD, 10'h2AA, sent when no source is valid
- clk50  in  1  50 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- gclk  in  1  10 MHz gated clock, asynchronous to clk50
- enable  in  1  run request from the Ebox controller
- sci_valid  in  1  science word available
- sci_data  in  WORD_BITS  science word
- sci_ready  out  1  science word accepted (one-cycle pulse)
- hk_valid  in  1  housekeeping word available
- hk_data  in  WORD_BITS  housekeeping word
- hk_ready  out  1  housekeeping word accepted (one-cycle pulse)
- sh_enable  out  1  drives the shifter enable
- sh_loadn  out  1  drives the shifter loadn (active low)
- sh_dbus  out  WORD_BITS  drives the shifter dbus_in
- frame_start  out  1  one-cycle pulse when the sync word loads
- word_idx  out  8  index of the word currently shifting
- underrun_cnt  out  16  count of fill words sent; saturates at 16'hFFFF

## Operation
- All outputs are registered.
- Reset values: sh_enable=0, sh_loadn=1, sh_dbus=0, sci_ready=0, hk_ready=0, frame_start=0, word_idx=0, underrun_cnt=0. State is IDLE, bit counter is 0, round-robin pointer is "sci next".
- gclk rising-edge detection: a 2-flop synchronizer plus an edge register, identical to the shifter's. Both blocks therefore detect the same edge in the same clk50 cycle.
- State machine:
  - IDLE: sh_enable=0. On enable=1, go to LOAD and set sh_enable=1.
  - LOAD: drive sh_loadn=0 for exactly one cycle with the selected word on sh_dbus, then go to SHIFT.
  - SHIFT: clear the bit counter on entry. Increment it on each detected gclk rising edge. On the edge that makes it WORD_BITS, go to LOAD and advance word_idx, wrapping FRAME_WORDS-1 to 0.
  - Any state: enable=0 returns to IDLE in the next cycle. sh_enable and sh_loadn return to reset values, the counter is cleared, and word_idx=0. underrun_cnt and the round-robin pointer keep their values.
- Word selection, evaluated in the LOAD cycle:
  - word_idx=0: SYNC_WORD, with frame_start=1.
  - Both sources valid: grant the source the round-robin pointer names, then flip the pointer.
  - One source valid: grant it; the pointer flips to the other source.
  - Neither valid: FILL_WORD, and underrun_cnt increments.
- The granted source's ready pulses in the LOAD cycle, and its data is sampled in that same cycle. Valid must hold until ready. A valid that rises after the LOAD cycle waits for the next word slot.
- A word is never granted during the sync slot.

## Timing
- First load: enable sampled high at cycle T gives sh_enable=1 at T+1 and sh_loadn=0 at T+1.
- Word period: WORD_BITS gclk rising edges, 1 µs at 10 MHz. The next load is the cycle after the WORD_BITS-th detected edge.
  - The last bit therefore shifts out on the edge the shifter detects in the same cycle.
  - The load cycle coincides with no new edge: edges are 5 clk50 cycles apart.
- Ready-to-shifter latency: 0 cycles. sh_dbus and sh_loadn are valid in the cycle ready is high, and the shifter captures on the following edge.
- Gated gclk stalls: the counter simply holds, and no timeout is applied.
- Async reset mid-word: all outputs go to reset values immediately. No partial-word recovery; the next enable starts a new frame at the sync word.
- Simultaneous enable fall and gclk edge: enable wins and the edge is ignored.

## Structure
- Shared package `ebox_tlm_pkg` holds:
  - WORD_BITS
  - SYNC_WORD and FILL_WORD constants
  - the state encoding (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2)
- One sub-module, `gclk_edge_det`: a 2-flop synchronizer plus rising-edge pulse with async reset. The shifter should adopt it later so edge alignment between the two blocks is guaranteed.

## Test plan
- Reset, then enable=1 with both sources idle, FRAME_WORDS=4:
  - sh_dbus sequence is 3C5, 2AA, 2AA, 2AA, 3C5.
  - Loads occur every 10 gclk edges.
  - underrun_cnt=3 after the first frame.
- Both sources valid continuously, sci_data=0x111, hk_data=0x222:
  - Data words alternate 111, 222, 111, …
  - Each ready pulses exactly once per grant.
  - No grant occurs in word 0.
- Only hk_valid=1 for three slots, then sci_valid=1 as well:
  - hk, hk, hk are granted, then sci, hk alternate.
- enable dropped at bit 4 of word 2:
  - sh_enable=0 the next cycle; no ready pulses.
  - Re-enable: the first load is 3C5 and frame_start=1.
- rst_n asserted mid-SHIFT:
  - All outputs take reset values asynchronously, including underrun_cnt=0.
- gclk stopped for 200 cycles mid-word:
  - No loads during the stop.
  - The word completes after the remaining edges; serial output matches the shifter model.
